// File: rtl/vreg_lane_sequencer.sv
// vreg_lane_sequencer: runs one vector instruction at a time.
// It reads both source vectors from the register file in one cycle and pushes
// the element pairs through the shared scalar ALU one lane per cycle. It then
// writes the result vector back in one cycle.
// Every output is a register, so downstream logic sees glitch-free controls.
module vreg_lane_sequencer #(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_vd,
  input  logic [AW-1:0] req_vs1,
  input  logic [AW-1:0] req_vs2,
  input  logic [2:0]    req_size,
  input  logic [2:0]    req_op,
  output logic          vrf_vector_op,
  output logic [2:0]    vrf_vector_size,
  output logic [AW-1:0] vrf_ra1,
  output logic [AW-1:0] vrf_ra2,
  output logic [AW-1:0] vrf_wa3,
  output logic          vrf_we3,
  output logic [DW-1:0] vrf_wd1,
  output logic [DW-1:0] vrf_wd2,
  output logic [DW-1:0] vrf_wd3,
  output logic [DW-1:0] vrf_wd4,
  output logic [DW-1:0] vrf_wd5,
  input  logic [DW-1:0] vrf_rd1,
  input  logic [DW-1:0] vrf_rd2,
  input  logic [DW-1:0] vrf_rd3,
  input  logic [DW-1:0] vrf_rd4,
  input  logic [DW-1:0] vrf_rd5,
  input  logic [DW-1:0] vrf_rd6,
  input  logic [DW-1:0] vrf_rd7,
  input  logic [DW-1:0] vrf_rd8,
  input  logic [DW-1:0] vrf_rd9,
  input  logic [DW-1:0] vrf_rd10,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_ctrl,
  input  logic [DW-1:0] alu_result,
  output logic          busy,
  output logic          done,
  output logic          err
);

  // The register file's lane count is fixed, so this is not a parameter.
  localparam int            NL      = 5;
  localparam logic [AW-1:0] BAD_REG = '1;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

  state_t        state;
  logic [AW-1:0] vd_q;
  logic [2:0]    size_q;
  logic [2:0]    op_q;
  logic [2:0]    lane_q;
  logic [2:0]    lane_nxt;
  logic [NL-1:0] lane_mask;
  logic          req_legal;

  logic [DW-1:0] rd_a [NL];
  logic [DW-1:0] rd_b [NL];
  logic [DW-1:0] a_q  [NL];
  logic [DW-1:0] b_q  [NL];
  logic [DW-1:0] r_q  [NL];
  logic [DW-1:0] wd_q [NL];

  assign rd_a[0] = vrf_rd1;
  assign rd_a[1] = vrf_rd2;
  assign rd_a[2] = vrf_rd3;
  assign rd_a[3] = vrf_rd4;
  assign rd_a[4] = vrf_rd5;
  assign rd_b[0] = vrf_rd6;
  assign rd_b[1] = vrf_rd7;
  assign rd_b[2] = vrf_rd8;
  assign rd_b[3] = vrf_rd9;
  assign rd_b[4] = vrf_rd10;

  assign vrf_wd1 = wd_q[0];
  assign vrf_wd2 = wd_q[1];
  assign vrf_wd3 = wd_q[2];
  assign vrf_wd4 = wd_q[3];
  assign vrf_wd5 = wd_q[4];

  // Request legality, active-lane mask and next lane index.
  always_comb begin
    // NOTE: default every always_comb output first so no path infers a latch.
    lane_mask = '0;
    for (int k = 0; k < NL; k++) lane_mask[k] = (3'(k) < size_q);
    lane_nxt  = lane_q + 3'd1;
    req_legal = (req_size != 3'd0) && (req_size <= 3'(NL)) &&
                (req_vd != BAD_REG) && (req_vs1 != BAD_REG) && (req_vs2 != BAD_REG);
  end

  // Sequencer FSM. It holds the instruction latches, the operand and result
  // registers, and all registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register in this block samples pre-edge values.
    if (!rst_n) begin
      state           <= IDLE;
      vd_q            <= '0;
      size_q          <= '0;
      op_q            <= '0;
      lane_q          <= '0;
      req_ready       <= 1'b1;
      busy            <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
      vrf_vector_op   <= 1'b0;
      vrf_vector_size <= '0;
      vrf_ra1         <= '0;
      vrf_ra2         <= '0;
      vrf_wa3         <= '0;
      vrf_we3         <= 1'b0;
      alu_a           <= '0;
      alu_b           <= '0;
      alu_ctrl        <= '0;
      // NOTE: the operand and result arrays are reset too. Stale lanes must
      // never reach the write port after an aborted instruction.
      for (int k = 0; k < NL; k++) begin
        a_q[k]  <= '0;
        b_q[k]  <= '0;
        r_q[k]  <= '0;
        wd_q[k] <= '0;
      end
    end else begin
      err  <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (req_legal) begin
              state           <= READ;
              vd_q            <= req_vd;
              size_q          <= req_size;
              op_q            <= req_op;
              req_ready       <= 1'b0;
              busy            <= 1'b1;
              vrf_vector_op   <= 1'b1;
              vrf_vector_size <= req_size;
              vrf_ra1         <= req_vs1;
              vrf_ra2         <= req_vs2;
              for (int k = 0; k < NL; k++) r_q[k] <= '0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        READ: begin
          for (int k = 0; k < NL; k++) begin
            a_q[k] <= lane_mask[k] ? rd_a[k] : '0;
            b_q[k] <= lane_mask[k] ? rd_b[k] : '0;
          end
          state           <= EXEC;
          lane_q          <= '0;
          vrf_vector_op   <= 1'b0;
          vrf_vector_size <= '0;
          vrf_ra1         <= '0;
          vrf_ra2         <= '0;
          // Every legal size has lane 0, so it is presented unmasked.
          alu_a           <= rd_a[0];
          alu_b           <= rd_b[0];
          alu_ctrl        <= op_q;
        end
        EXEC: begin
          r_q[lane_q] <= alu_result;
          if (lane_q == size_q - 3'd1) begin
            state           <= WRITE;
            alu_a           <= '0;
            alu_b           <= '0;
            alu_ctrl        <= '0;
            vrf_vector_op   <= 1'b1;
            vrf_vector_size <= size_q;
            vrf_wa3         <= vd_q;
            vrf_we3         <= 1'b1;
            done            <= 1'b1;
            // Lanes past size are still zero from the clear at accept.
            for (int k = 0; k < NL; k++)
              wd_q[k] <= (3'(k) == lane_q) ? alu_result : r_q[k];
          end else begin
            lane_q <= lane_nxt;
            alu_a  <= a_q[lane_nxt];
            alu_b  <= b_q[lane_nxt];
          end
        end
        WRITE: begin
          state           <= IDLE;
          req_ready       <= 1'b1;
          busy            <= 1'b0;
          vrf_vector_op   <= 1'b0;
          vrf_vector_size <= '0;
          vrf_wa3         <= '0;
          vrf_we3         <= 1'b0;
          for (int k = 0; k < NL; k++) wd_q[k] <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
